// File: rtl/ins_exec_wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// ins_exec_pkg : shared constants and types for the exec write-back scheduler
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ins_exec_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ins_exec_wb_sched_if.sv
// ---------------------------------------------------------------------------
// ins_exec_wb_sched_if : exec-unit request bundles, write ports and fetch flush
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ins_exec_wb_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
);

  localparam int IW = ins_exec_pkg::REG_IDX_W;

  logic [NUM_REQ-1:0]      req_reg_w_op;
  logic [NUM_REQ*IW-1:0]   req_reg_w_reg_idx;
  logic [NUM_REQ*XLEN-1:0] req_reg_w_reg_val;
  logic [NUM_REQ-1:0]      req_pc_w_op;
  logic [NUM_REQ*XLEN-1:0] req_pc_w_val;
  logic [NUM_REQ-1:0]      req_grant;

  logic                    reg_w_op;
  logic [IW-1:0]           reg_w_reg_idx;
  logic [XLEN-1:0]         reg_w_reg_val;
  logic                    reg_pc_w_op;
  logic [XLEN-1:0]         reg_pc_w_val;

  logic                    fetch_flush;
  logic                    fetch_flush_ack;
  logic                    exc_misalign;
  logic [XLEN-1:0]         exc_misalign_val;

  modport master (
    output req_reg_w_op, req_reg_w_reg_idx, req_reg_w_reg_val,
    output req_pc_w_op, req_pc_w_val, fetch_flush_ack,
    input  req_grant, reg_w_op, reg_w_reg_idx, reg_w_reg_val,
    input  reg_pc_w_op, reg_pc_w_val, fetch_flush, exc_misalign, exc_misalign_val
  );

  modport slave (
    input  req_reg_w_op, req_reg_w_reg_idx, req_reg_w_reg_val,
    input  req_pc_w_op, req_pc_w_val, fetch_flush_ack,
    output req_grant, reg_w_op, reg_w_reg_idx, reg_w_reg_val,
    output reg_pc_w_op, reg_pc_w_val, fetch_flush, exc_misalign, exc_misalign_val
  );

endinterface

`default_nettype wire

// File: rtl/ins_exec_wb_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts at ptr
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0]  req,
  input  wire logic [PW-1:0] ptr,
  output logic      [N-1:0]  grant,
  output logic      [PW-1:0] grant_idx
);

  logic [PW:0] w_cand;
  logic        w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(N)) begin
        w_cand = w_cand - (PW+1)'(N);
      end
      if (!w_found && req[w_cand]) begin
        w_found        = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = w_cand[PW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ins_exec_wb_sched.sv
// ---------------------------------------------------------------------------
// ins_exec_wb_sched : round-robin write-back scheduler with redirect flush
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ins_exec_wb_sched #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
) (
  input wire logic           clk,
  input wire logic           rst,
  ins_exec_wb_sched_if.slave bus
);

  import ins_exec_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   reg_op_q, reg_op_d;
  logic [REG_IDX_W-1:0]   reg_idx_q, reg_idx_d;
  logic [XLEN-1:0]        reg_val_q, reg_val_d;
  logic                   pc_op_q, pc_op_d;
  logic [XLEN-1:0]        pc_val_q, pc_val_d;
  logic                   exc_q, exc_d;
  logic [XLEN-1:0]        exc_val_q, exc_val_d;

  logic [REG_IDX_W-1:0]   idx_arr [NUM_REQ];
  logic [XLEN-1:0]        val_arr [NUM_REQ];
  logic [XLEN-1:0]        pc_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]     arb_req;
  logic [NUM_REQ-1:0]     grant;
  logic [PW-1:0]          grant_idx;
  logic [XLEN-1:0]        target;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign idx_arr[i] = bus.req_reg_w_reg_idx[i*REG_IDX_W +: REG_IDX_W];
    assign val_arr[i] = bus.req_reg_w_reg_val[i*XLEN +: XLEN];
    assign pc_arr[i]  = bus.req_pc_w_val[i*XLEN +: XLEN];
  end

  // Grants are only offered while no redirect is outstanding.
  assign arb_req = (state_q == ST_IDLE) ? (bus.req_reg_w_op | bus.req_pc_w_op) : '0;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req       (arb_req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign target = pc_arr[grant_idx] & ~XLEN'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    reg_op_d  = 1'b0;
    reg_idx_d = '0;
    reg_val_d = '0;
    pc_op_d   = 1'b0;
    pc_val_d  = '0;
    exc_d     = 1'b0;
    exc_val_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          ptr_d = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          if (bus.req_pc_w_op[grant_idx] && target[1]) begin
            // Misaligned redirect kills the whole bundle, link write included.
            exc_d     = 1'b1;
            exc_val_d = target;
          end else begin
            if (idx_arr[grant_idx] != '0) begin
              reg_op_d  = bus.req_reg_w_op[grant_idx];
              reg_idx_d = idx_arr[grant_idx];
              reg_val_d = val_arr[grant_idx];
            end
            if (bus.req_pc_w_op[grant_idx]) begin
              pc_op_d  = 1'b1;
              pc_val_d = target;
              state_d  = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (bus.fetch_flush_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      reg_op_q  <= 1'b0;
      reg_idx_q <= '0;
      reg_val_q <= '0;
      pc_op_q   <= 1'b0;
      pc_val_q  <= '0;
      exc_q     <= 1'b0;
      exc_val_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      reg_op_q  <= reg_op_d;
      reg_idx_q <= reg_idx_d;
      reg_val_q <= reg_val_d;
      pc_op_q   <= pc_op_d;
      pc_val_q  <= pc_val_d;
      exc_q     <= exc_d;
      exc_val_q <= exc_val_d;
    end
  end

  assign bus.req_grant        = grant;
  assign bus.reg_w_op         = reg_op_q;
  assign bus.reg_w_reg_idx    = reg_idx_q;
  assign bus.reg_w_reg_val    = reg_val_q;
  assign bus.reg_pc_w_op      = pc_op_q;
  assign bus.reg_pc_w_val     = pc_val_q;
  assign bus.fetch_flush      = (state_q == ST_FLUSH);
  assign bus.exc_misalign     = exc_q;
  assign bus.exc_misalign_val = exc_val_q;

endmodule

`default_nettype wire

// File: tb/tb_ins_exec_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_ins_exec_wb_sched : directed self-checking bench for ins_exec_wb_sched
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ins_exec_wb_sched;

  localparam int NUM_REQ = 4;
  localparam int XLEN    = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ins_exec_wb_sched_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  ins_exec_wb_sched #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rop, input logic [4:0] idx,
                         input logic [31:0] val, input logic pop, input logic [31:0] pval);
    bus.req_reg_w_op[i]             = rop;
    bus.req_reg_w_reg_idx[i*5 +: 5] = idx;
    bus.req_reg_w_reg_val[i*32 +: 32] = val;
    bus.req_pc_w_op[i]              = pop;
    bus.req_pc_w_val[i*32 +: 32]    = pval;
  endtask

  task automatic clear_req(input int i);
    set_req(i, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic check_wb(input string tag, input logic rop, input logic [4:0] idx,
                          input logic [31:0] val, input logic pop, input logic [31:0] pval);
    check_eq({tag, ".reg_w_op"},      64'(bus.reg_w_op),      64'(rop));
    check_eq({tag, ".reg_w_reg_idx"}, 64'(bus.reg_w_reg_idx), 64'(idx));
    check_eq({tag, ".reg_w_reg_val"}, 64'(bus.reg_w_reg_val), 64'(val));
    check_eq({tag, ".reg_pc_w_op"},   64'(bus.reg_pc_w_op),   64'(pop));
    check_eq({tag, ".reg_pc_w_val"},  64'(bus.reg_pc_w_val),  64'(pval));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req_reg_w_op      = '0;
    bus.req_reg_w_reg_idx = '0;
    bus.req_reg_w_reg_val = '0;
    bus.req_pc_w_op       = '0;
    bus.req_pc_w_val      = '0;
    bus.fetch_flush_ack   = 1'b0;

    // Reset state
    #2;
    check_wb("reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    check_eq("reset.fetch_flush", 64'(bus.fetch_flush), 64'd0);
    check_eq("reset.exc_misalign", 64'(bus.exc_misalign), 64'd0);
    check_eq("reset.exc_misalign_val", 64'(bus.exc_misalign_val), 64'd0);
    check_eq("reset.req_grant", 64'(bus.req_grant), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Round-robin from pointer 0, all four requesters held
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 32'd0);
    for (int k = 0; k < NUM_REQ; k++) begin
      #1;
      check_eq($sformatf("rr.grant%0d", k), 64'(bus.req_grant), 64'(4'b0001 << k));
      step();
      check_wb($sformatf("rr.out%0d", k), 1'b1, 5'(k + 1), 32'h100 + 32'(k), 1'b0, 32'd0);
    end
    for (int i = 0; i < NUM_REQ; i++) clear_req(i);
    step();
    check_wb("idle.out", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // Single register write (pointer back at 0)
    set_req(0, 1'b1, 5'd5, 32'h1234, 1'b0, 32'd0);
    #1;
    check_eq("single.grant", 64'(bus.req_grant), 64'b0001);
    step();
    clear_req(0);
    check_wb("single.out", 1'b1, 5'd5, 32'h1234, 1'b0, 32'd0);

    // JALR link + redirect; req1 must wait for the flush handshake
    set_req(2, 1'b1, 5'd1, 32'h104, 1'b1, 32'h2001);
    #1;
    check_eq("jalr.grant", 64'(bus.req_grant), 64'b0100);
    step();
    clear_req(2);
    set_req(1, 1'b1, 5'd3, 32'h55, 1'b0, 32'd0);
    check_wb("jalr.out", 1'b1, 5'd1, 32'h104, 1'b1, 32'h2000);
    check_eq("jalr.flush", 64'(bus.fetch_flush), 64'd1);
    #1;
    check_eq("jalr.grant_blocked0", 64'(bus.req_grant), 64'd0);
    step();
    check_eq("jalr.flush_hold", 64'(bus.fetch_flush), 64'd1);
    check_wb("jalr.out_pulse", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    bus.fetch_flush_ack = 1'b1;
    #1;
    check_eq("jalr.grant_blocked1", 64'(bus.req_grant), 64'd0);
    step();
    check_eq("jalr.flush_drop", 64'(bus.fetch_flush), 64'd0);
    #1;
    check_eq("jalr.grant_resume", 64'(bus.req_grant), 64'b0010);
    bus.fetch_flush_ack = 1'b0;
    step();
    clear_req(1);
    check_wb("jalr.resume_out", 1'b1, 5'd3, 32'h55, 1'b0, 32'd0);

    // Misaligned redirect target (pointer at 2)
    set_req(3, 1'b1, 5'd4, 32'h9, 1'b1, 32'h2002);
    #1;
    check_eq("mis.grant", 64'(bus.req_grant), 64'b1000);
    step();
    clear_req(3);
    check_eq("mis.exc", 64'(bus.exc_misalign), 64'd1);
    check_eq("mis.exc_val", 64'(bus.exc_misalign_val), 64'h2002);
    check_eq("mis.reg_op", 64'(bus.reg_w_op), 64'd0);
    check_eq("mis.pc_op", 64'(bus.reg_pc_w_op), 64'd0);
    check_eq("mis.flush", 64'(bus.fetch_flush), 64'd0);
    set_req(0, 1'b1, 5'd6, 32'h7, 1'b0, 32'd0);
    #1;
    check_eq("mis.next_grant", 64'(bus.req_grant), 64'b0001);
    step();
    clear_req(0);
    check_wb("mis.next_out", 1'b1, 5'd6, 32'h7, 1'b0, 32'd0);
    check_eq("mis.exc_pulse", 64'(bus.exc_misalign), 64'd0);

    // Write to x0 is consumed but suppressed (pointer at 1)
    set_req(1, 1'b1, 5'd0, 32'hFFFF, 1'b0, 32'd0);
    #1;
    check_eq("x0.grant", 64'(bus.req_grant), 64'b0010);
    step();
    clear_req(1);
    check_wb("x0.out", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // Ack already high on FLUSH entry: one-cycle flush (pointer at 2)
    bus.fetch_flush_ack = 1'b1;
    set_req(2, 1'b0, 5'd0, 32'd0, 1'b1, 32'h3000);
    #1;
    check_eq("ackhi.grant", 64'(bus.req_grant), 64'b0100);
    step();
    clear_req(2);
    check_wb("ackhi.out", 1'b0, 5'd0, 32'd0, 1'b1, 32'h3000);
    check_eq("ackhi.flush", 64'(bus.fetch_flush), 64'd1);
    set_req(3, 1'b1, 5'd9, 32'h1, 1'b0, 32'd0);
    #1;
    check_eq("ackhi.grant_blocked", 64'(bus.req_grant), 64'd0);
    step();
    check_eq("ackhi.flush_drop", 64'(bus.fetch_flush), 64'd0);
    #1;
    check_eq("ackhi.grant_resume", 64'(bus.req_grant), 64'b1000);
    step();
    clear_req(3);
    bus.fetch_flush_ack = 1'b0;
    check_wb("ackhi.resume_out", 1'b1, 5'd9, 32'h1, 1'b0, 32'd0);

    // Reset asserted mid-FLUSH (pointer at 0, becomes 1 after this grant)
    set_req(0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h4000);
    #1;
    check_eq("rstfl.grant", 64'(bus.req_grant), 64'b0001);
    step();
    clear_req(0);
    check_eq("rstfl.flush", 64'(bus.fetch_flush), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rstfl.flush_async", 64'(bus.fetch_flush), 64'd0);
    check_wb("rstfl.out_async", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd8, 32'h80, 1'b0, 32'd0);
    set_req(1, 1'b1, 5'd10, 32'hA0, 1'b0, 32'd0);
    #1;
    check_eq("rstfl.ptr0_grant", 64'(bus.req_grant), 64'b0001);
    check_eq("rstfl.idle", 64'(bus.fetch_flush), 64'd0);
    step();
    clear_req(0);
    check_wb("rstfl.out", 1'b1, 5'd8, 32'h80, 1'b0, 32'd0);
    #1;
    check_eq("rstfl.next_grant", 64'(bus.req_grant), 64'b0010);
    step();
    clear_req(1);
    check_wb("rstfl.next_out", 1'b1, 5'd10, 32'hA0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
